dt_engine_param: RTL

//  Parametrised two-pass distance-transform engine; successor to the fixed 128x128 chessboard DT.

---
 rtl/dt_engine_param.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/dt_engine_param.sv
// dt_engine_param: two-pass chessboard/city-block distance transform of a packed sti bitmap.
// Define DT_MAXDIST_EN to add max_dist, the largest distance written by the last run.
module dt_engine_param #(
    parameter int IMG_LOG2W = 7,
    parameter int IMG_LOG2H = 7,
    parameter int STI_W     = 16,
    parameter int RES_W     = 8
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         start,
    input  logic                                         metric,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         sti_rd,
    output logic [IMG_LOG2W+IMG_LOG2H-$clog2(STI_W)-1:0] sti_addr,
    input  logic [STI_W-1:0]                             sti_di,
    output logic                                         res_rd,
    output logic                                         res_wr,
    output logic [IMG_LOG2W+IMG_LOG2H-1:0]               res_addr,
    output logic [RES_W-1:0]                             res_do,
    input  logic [RES_W-1:0]                             res_di
`ifdef DT_MAXDIST_EN
    ,
    output logic [RES_W-1:0]                             max_dist
`endif
);

    localparam int AW = IMG_LOG2W + IMG_LOG2H;
    localparam int SL = $clog2(STI_W);
    localparam logic [IMG_LOG2H-1:0] R1 = 1;
    localparam logic [IMG_LOG2W-1:0] C1 = 1;
    localparam logic [RES_W-1:0]     V1 = 1;

    typedef enum logic [3:0] {
        S_IDLE, S_PIX, S_STI_RD, S_STI_CAP, S_N_RD, S_N_CAP,
        S_NE_RD, S_NE_CAP, S_F_RD, S_F_CAP, S_WR, S_DONE
    } state_t;

    state_t state, state_nx, disp;

    logic                 met, bwd;
    logic [IMG_LOG2H-1:0] lr, lr_up;
    logic [IMG_LOG2W-1:0] lc, lc_nx;
    logic [STI_W-1:0]     sti_word;
    logic [RES_W-1:0]     va, vb, vc, vw, vf;
    logic [RES_W-1:0]     mn, inc, wr_val;
    logic [AW-1:0]        mask, pix_addr, n_addr, ne_addr;
    logic                 border, obj, wr_en;

    function automatic logic [RES_W-1:0] min2(input logic [RES_W-1:0] x,
                                              input logic [RES_W-1:0] y);
        return (x < y) ? x : y;
    endfunction

    // The backward pass runs the forward datapath on bit-inverted coordinates,
    // so "previous row" and "next column" are always lr-1 and lc+1.
    assign mask     = {AW{bwd}};
    assign lr_up    = lr - R1;
    assign lc_nx    = lc + C1;
    assign pix_addr = {lr, lc} ^ mask;
    assign n_addr   = {lr_up, lc} ^ mask;
    assign ne_addr  = {lr_up, lc_nx} ^ mask;

    assign border = (lr == '0) || (&lr) || (lc == '0) || (&lc);
    assign obj    = sti_word[lc[SL-1:0] ^ {SL{~bwd}}];

    assign mn     = met ? min2(vw, vb) : min2(min2(vw, va), min2(vb, vc));
    assign inc    = (&mn) ? mn : mn + V1;
    assign wr_val = (!border && obj) ? (bwd ? min2(vf, inc) : inc) : '0;
    assign wr_en  = (state == S_WR) && (!bwd || (!border && obj));

    assign disp = border ? S_WR : ((lc == C1) ? S_N_RD : S_NE_RD);

`ifdef DT_MAXDIST_EN
    logic [RES_W-1:0] max_q;
    assign max_dist = max_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            met      <= 1'b0;
            bwd      <= 1'b0;
            lr       <= '0;
            lc       <= '0;
            sti_word <= '0;
            va       <= '0;
            vb       <= '0;
            vc       <= '0;
            vw       <= '0;
            vf       <= '0;
`ifdef DT_MAXDIST_EN
            max_q    <= '0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: if (start) begin
                    met <= metric;
                    bwd <= 1'b0;
                    lr  <= '0;
                    lc  <= '0;
`ifdef DT_MAXDIST_EN
                    max_q <= '0;
`endif
                end
                S_STI_CAP: sti_word <= sti_di;
                S_N_CAP: begin
                    va <= '0;
                    vb <= res_di;
                end
                S_NE_CAP: vc <= res_di;
                S_F_CAP:  vf <= res_di;
                S_WR: begin
                    vw <= wr_val;
                    va <= vb;
                    vb <= vc;
`ifdef DT_MAXDIST_EN
                    if (wr_en && wr_val > max_q) max_q <= wr_val;
`endif
                    if (&lc) begin
                        lc <= '0;
                        if (&lr) begin
                            lr  <= '0;
                            bwd <= ~bwd;
                        end else begin
                            lr <= lr + R1;
                        end
                    end else begin
                        lc <= lc_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (start) state_nx = S_PIX;
            S_PIX:     state_nx = (lc[SL-1:0] == '0) ? S_STI_RD : disp;
            S_STI_RD:  state_nx = S_STI_CAP;
            S_STI_CAP: state_nx = disp;
            S_N_RD:    state_nx = S_N_CAP;
            S_N_CAP:   state_nx = S_NE_RD;
            S_NE_RD:   state_nx = S_NE_CAP;
            S_NE_CAP:  state_nx = (bwd && obj) ? S_F_RD : S_WR;
            S_F_RD:    state_nx = S_F_CAP;
            S_F_CAP:   state_nx = S_WR;
            S_WR:      state_nx = ((&lc) && (&lr) && bwd) ? S_DONE : S_PIX;
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        sti_rd   = 1'b0;
        sti_addr = '0;
        res_rd   = 1'b0;
        res_wr   = 1'b0;
        res_addr = '0;
        res_do   = '0;
        if (!reset) begin
            busy = (state != S_IDLE) && (state != S_DONE);
            done = (state == S_DONE);
            case (state)
                S_STI_RD: begin
                    sti_rd   = 1'b1;
                    sti_addr = pix_addr[AW-1:SL];
                end
                S_N_RD: begin
                    res_rd   = 1'b1;
                    res_addr = n_addr;
                end
                S_NE_RD: begin
                    res_rd   = 1'b1;
                    res_addr = ne_addr;
                end
                S_F_RD: begin
                    res_rd   = 1'b1;
                    res_addr = pix_addr;
                end
                S_WR: if (wr_en) begin
                    res_wr   = 1'b1;
                    res_addr = pix_addr;
                    res_do   = wr_val;
                end
                default: ;
            endcase
        end
    end

endmodule
